sd_clk_ctrl: RTL and testbench

SD card clock controller. It sequences the card-clock divider: it programs the divide value, holds the divider in reset across reconfiguration, and gates the divider output onto the card clock pin only on low phases. It also reports when the clock has settled. It sits between the host register block / data path and the clock divider instance in the SD host controller.

---
 rtl/sd_clk_ctrl.sv | 129 ++++++++++++
 tb/tb_sd_clk_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sd_clk_ctrl.sv
// SD card clock controller: programs the divider, holds it in reset across
// reconfiguration and gates its output on low phases. SD_CLK_AUTO_STOP_EN enables hold-driven pause.
module sd_clk_ctrl #(
  parameter logic [15:0] INIT_DIV     = 16'd500,
  parameter int          STABLE_EDGES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en_req,
  input  logic        div_wr,
  input  logic [15:0] div_in,
  input  logic        hold,
  input  logic        sd_clk_raw,
  output logic [15:0] div_count,
  output logic        div_rst,
  output logic        sd_clk,
  output logic        clk_stable,
  output logic        busy
);

  typedef enum logic [2:0] {S_OFF, S_RESTART, S_SETTLE, S_RUN, S_PAUSE} state_t;

  localparam logic [7:0] LAST_EDGE = 8'(STABLE_EDGES - 1);

  state_t      state, nxt;
  logic [15:0] div_sh;
  logic        raw_q, gate_q, gate_nxt, rst_cnt;
  logic [7:0]  edge_cnt;
  logic        pend_off, pend_rs, pend_ps;
  logic        hold_req, fall_det, rise_det;
  logic        want_off, want_rs, want_ps;

`ifdef SD_CLK_AUTO_STOP_EN
  assign hold_req = hold;
`else
  assign hold_req = hold & 1'b0;
`endif

  assign fall_det = raw_q & ~sd_clk_raw;
  assign rise_det = ~raw_q & sd_clk_raw;
  // Requests arriving on the fall_det cycle itself count as pending.
  assign want_off = pend_off | ~clk_en_req;
  assign want_rs  = pend_rs | div_wr;
  assign want_ps  = pend_ps | hold_req;

  always_comb begin
    nxt      = state;
    gate_nxt = gate_q;
    case (state)
      S_OFF: begin
        gate_nxt = 1'b0;
        if (clk_en_req) nxt = S_RESTART;
      end
      S_RESTART: begin
        gate_nxt = 1'b0;
        if (rst_cnt) nxt = S_SETTLE;
      end
      S_SETTLE: begin
        gate_nxt = 1'b0;
        if (!clk_en_req)                           nxt = S_OFF;
        else if (div_wr)                           nxt = S_RESTART;
        else if (rise_det && edge_cnt == LAST_EDGE) nxt = S_RUN;
      end
      S_RUN: begin
        if (fall_det) begin
          if (want_off)     begin nxt = S_OFF;     gate_nxt = 1'b0; end
          else if (want_rs) begin nxt = S_RESTART; gate_nxt = 1'b0; end
          else if (want_ps) begin nxt = S_PAUSE;   gate_nxt = 1'b0; end
          else                    gate_nxt = 1'b1;
        end
      end
      S_PAUSE: begin
        gate_nxt = 1'b0;
        if (!clk_en_req)              nxt = S_OFF;
        else if (div_wr)              nxt = S_RESTART;
        else if (!hold_req && fall_det) begin
          nxt      = S_RUN;
          gate_nxt = 1'b1;
        end
      end
      default: begin
        nxt      = S_OFF;
        gate_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_OFF;
      gate_q    <= 1'b0;
      raw_q     <= 1'b0;
      div_sh    <= INIT_DIV;
      div_count <= INIT_DIV;
      rst_cnt   <= 1'b0;
      edge_cnt  <= '0;
      pend_off  <= 1'b0;
      pend_rs   <= 1'b0;
      pend_ps   <= 1'b0;
    end else begin
      state   <= nxt;
      gate_q  <= gate_nxt;
      raw_q   <= sd_clk_raw;
      rst_cnt <= (state == S_RESTART);
      // Minimum of 4 keeps the divider low phase at two clk or more.
      if (div_wr) div_sh <= (div_in < 16'd4) ? 16'd4 : div_in;
      // Reloaded on every cycle heading into RESTART so a late div_wr is still picked up.
      if (nxt == S_RESTART) div_count <= div_sh;
      if (state != S_SETTLE) edge_cnt <= '0;
      else if (rise_det)     edge_cnt <= edge_cnt + 8'd1;
      if (state == S_RUN) begin
        pend_off <= pend_off | ~clk_en_req;
        pend_rs  <= pend_rs | div_wr;
        pend_ps  <= pend_ps | hold_req;
      end else begin
        pend_off <= 1'b0;
        pend_rs  <= 1'b0;
        pend_ps  <= 1'b0;
      end
    end
  end

  assign div_rst    = (state == S_OFF) || (state == S_RESTART);
  assign sd_clk     = sd_clk_raw & gate_q;
  assign clk_stable = (state == S_RUN) || (state == S_PAUSE);
  assign busy       = (state == S_RESTART) || (state == S_SETTLE) ||
                      ((state == S_RUN) && (pend_off || pend_rs));

endmodule

// File: tb/tb_sd_clk_ctrl.sv
// Directed bench for sd_clk_ctrl with a behavioural clock divider model.
module tb_sd_clk_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_en_req = 1'b0;
  logic        div_wr = 1'b0;
  logic [15:0] div_in = '0;
  logic        hold = 1'b0;
  logic        raw = 1'b0;
  logic [15:0] div_count;
  logic        div_rst, sd_clk, clk_stable, busy;
  logic [15:0] dcnt = '0;
  int          pass_cnt = 0;
  int          chk_cnt = 0;

  sd_clk_ctrl dut (
    .clk(clk), .reset(reset), .clk_en_req(clk_en_req), .div_wr(div_wr),
    .div_in(div_in), .hold(hold), .sd_clk_raw(raw), .div_count(div_count),
    .div_rst(div_rst), .sd_clk(sd_clk), .clk_stable(clk_stable), .busy(busy)
  );

  always #5 clk = ~clk;

  // Divider: half period of (D>>2)+1 clk, output registered, held low in reset.
  always @(posedge clk) begin
    if (div_rst) begin
      dcnt <= '0;
      raw  <= 1'b0;
    end else if (dcnt == (div_count >> 2)) begin
      dcnt <= '0;
      raw  <= ~raw;
    end else begin
      dcnt <= dcnt + 16'd1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cur(input int sel);
    case (sel)
      0:       return sd_clk;
      1:       return clk_stable;
      2:       return div_rst;
      default: return raw;
    endcase
  endfunction

  // Cycles until the selected signal reaches val; -1 on timeout.
  task automatic wait_sig(input int sel, input logic val, input int maxc, output int n);
    n = 0;
    while (cur(sel) !== val && n < maxc) begin
      step();
      n++;
    end
    if (cur(sel) !== val) n = -1;
  endtask

  task automatic test_reset();
    step(); step();
    chk_cnt++; if (div_count !== 16'd500) $display("FAIL rst_div_count got %0d want 500", div_count); else pass_cnt++;
    chk_cnt++; if (div_rst !== 1'b1) $display("FAIL rst_div_rst got %b want 1", div_rst); else pass_cnt++;
    chk_cnt++; if (sd_clk !== 1'b0) $display("FAIL rst_sd_clk got %b want 0", sd_clk); else pass_cnt++;
    chk_cnt++; if (clk_stable !== 1'b0) $display("FAIL rst_clk_stable got %b want 0", clk_stable); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_startup();
    int n;
    reset = 1'b1;
    clk_en_req = 1'b1;
    wait_sig(2, 1'b0, 10, n);
    chk_cnt++; if (n !== 3) $display("FAIL start_div_rst_fall got %0d want 3", n); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b1) $display("FAIL start_busy got %b want 1", busy); else pass_cnt++;
    wait_sig(1, 1'b1, 3000, n);
    chk_cnt++; if (n !== 1891) $display("FAIL start_stable got %0d want 1891", n); else pass_cnt++;
    chk_cnt++; if (div_count !== 16'd500) $display("FAIL start_div_count got %0d want 500", div_count); else pass_cnt++;
    wait_sig(0, 1'b1, 600, n);
    chk_cnt++; if (n !== 251) $display("FAIL start_first_high got %0d want 251", n); else pass_cnt++;
    wait_sig(0, 1'b0, 600, n);
    chk_cnt++; if (n !== 126) $display("FAIL start_high_width got %0d want 126", n); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL start_busy_run got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_div_change();
    int n;
    repeat (10) step();
    div_wr = 1'b1;
    div_in = 16'd8;
    step();
    div_wr = 1'b0;
    chk_cnt++; if (busy !== 1'b1) $display("FAIL div8_busy_pend got %b want 1", busy); else pass_cnt++;
    chk_cnt++; if (clk_stable !== 1'b1) $display("FAIL div8_stable_pend got %b want 1", clk_stable); else pass_cnt++;
    wait_sig(1, 1'b0, 600, n);
    chk_cnt++; if (n !== 242) $display("FAIL div8_stop_lat got %0d want 242", n); else pass_cnt++;
    chk_cnt++; if (div_rst !== 1'b1) $display("FAIL div8_div_rst got %b want 1", div_rst); else pass_cnt++;
    chk_cnt++; if (div_count !== 16'd8) $display("FAIL div8_div_count got %0d want 8", div_count); else pass_cnt++;
    chk_cnt++; if (sd_clk !== 1'b0) $display("FAIL div8_sd_clk got %b want 0", sd_clk); else pass_cnt++;
    wait_sig(2, 1'b0, 20, n);
    chk_cnt++; if (n !== 2) $display("FAIL div8_rst_len got %0d want 2", n); else pass_cnt++;
    wait_sig(1, 1'b1, 200, n);
    chk_cnt++; if (n !== 46) $display("FAIL div8_stable got %0d want 46", n); else pass_cnt++;
    wait_sig(0, 1'b1, 50, n);
    chk_cnt++; if (n !== 5) $display("FAIL div8_first_high got %0d want 5", n); else pass_cnt++;
    wait_sig(0, 1'b0, 50, n);
    chk_cnt++; if (n !== 3) $display("FAIL div8_high_width got %0d want 3", n); else pass_cnt++;
    wait_sig(0, 1'b1, 50, n);
    chk_cnt++; if (n !== 3) $display("FAIL div8_low_width got %0d want 3", n); else pass_cnt++;
  endtask

  task automatic test_min_div();
    int n;
    int run = 0;
    int min_high = 99;
    int pulses = 0;
    div_wr = 1'b1;
    div_in = 16'd1;
    step();
    div_wr = 1'b0;
    wait_sig(1, 1'b0, 50, n);
    chk_cnt++; if (n !== 3) $display("FAIL min_stop_lat got %0d want 3", n); else pass_cnt++;
    chk_cnt++; if (div_count !== 16'd4) $display("FAIL min_div_count got %0d want 4", div_count); else pass_cnt++;
    wait_sig(1, 1'b1, 200, n);
    chk_cnt++; if (n !== 33) $display("FAIL min_stable got %0d want 33", n); else pass_cnt++;
    for (int k = 0; k < 40; k++) begin
      step();
      if (sd_clk) run++;
      else if (run > 0) begin
        if (run < min_high) min_high = run;
        pulses++;
        run = 0;
      end
    end
    chk_cnt++; if (min_high !== 2) $display("FAIL min_high_pulse got %0d want 2", min_high); else pass_cnt++;
    chk_cnt++; if (pulses !== 9) $display("FAIL min_pulses got %0d want 9", pulses); else pass_cnt++;
  endtask

  task automatic test_hold();
    int n;
    int highs = 0;
    int drops = 0;
    int exp_highs, exp_resume;
`ifdef SD_CLK_AUTO_STOP_EN
    exp_highs = 2;
    exp_resume = 8;
`else
    exp_highs = 20;
    exp_resume = 2;
`endif
    div_wr = 1'b1;
    div_in = 16'd8;
    step();
    div_wr = 1'b0;
    wait_sig(1, 1'b0, 50, n);
    chk_cnt++; if (n !== 1) $display("FAIL hold_restart_lat got %0d want 1", n); else pass_cnt++;
    wait_sig(1, 1'b1, 200, n);
    chk_cnt++; if (n !== 48) $display("FAIL hold_stable got %0d want 48", n); else pass_cnt++;
    wait_sig(0, 1'b1, 50, n);
    chk_cnt++; if (n !== 5) $display("FAIL hold_first_high got %0d want 5", n); else pass_cnt++;
    hold = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (sd_clk) highs++;
      if (!clk_stable) drops++;
    end
    hold = 1'b0;
    chk_cnt++; if (highs !== exp_highs) $display("FAIL hold_high_cycles got %0d want %0d", highs, exp_highs); else pass_cnt++;
    chk_cnt++; if (drops !== 0) $display("FAIL hold_stable_drops got %0d want 0", drops); else pass_cnt++;
    wait_sig(0, 1'b1, 50, n);
    chk_cnt++; if (n !== exp_resume) $display("FAIL hold_resume got %0d want %0d", n, exp_resume); else pass_cnt++;
  endtask

  task automatic test_off_and_wr();
    int n;
    clk_en_req = 1'b0;
    div_wr = 1'b1;
    div_in = 16'd100;
    step();
    div_wr = 1'b0;
    chk_cnt++; if (busy !== 1'b1) $display("FAIL off_busy_pend got %b want 1", busy); else pass_cnt++;
    wait_sig(1, 1'b0, 50, n);
    chk_cnt++; if (n !== 3) $display("FAIL off_lat got %0d want 3", n); else pass_cnt++;
    chk_cnt++; if (div_rst !== 1'b1) $display("FAIL off_div_rst got %b want 1", div_rst); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL off_busy got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (div_count !== 16'd8) $display("FAIL off_div_count got %0d want 8", div_count); else pass_cnt++;
    repeat (4) step();
    clk_en_req = 1'b1;
    wait_sig(2, 1'b0, 10, n);
    chk_cnt++; if (n !== 3) $display("FAIL on_div_rst_fall got %0d want 3", n); else pass_cnt++;
    chk_cnt++; if (div_count !== 16'd100) $display("FAIL on_div_count got %0d want 100", div_count); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n;
    for (int k = 0; k < 5; k++) begin
      wait_sig(3, 1'b1, 200, n);
      wait_sig(3, 1'b0, 200, n);
    end
    chk_cnt++; if (busy !== 1'b1) $display("FAIL mid_busy_settle got %b want 1", busy); else pass_cnt++;
    #2;
    reset = 1'b0;
    #1;
    chk_cnt++; if (div_count !== 16'd500) $display("FAIL mid_div_count got %0d want 500", div_count); else pass_cnt++;
    chk_cnt++; if (div_rst !== 1'b1) $display("FAIL mid_div_rst got %b want 1", div_rst); else pass_cnt++;
    chk_cnt++; if (sd_clk !== 1'b0) $display("FAIL mid_sd_clk got %b want 0", sd_clk); else pass_cnt++;
    chk_cnt++; if (clk_stable !== 1'b0) $display("FAIL mid_clk_stable got %b want 0", clk_stable); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL mid_busy got %b want 0", busy); else pass_cnt++;
    step();
    reset = 1'b1;
    wait_sig(2, 1'b0, 10, n);
    chk_cnt++; if (n !== 3) $display("FAIL mid_restart got %0d want 3", n); else pass_cnt++;
    chk_cnt++; if (div_count !== 16'd500) $display("FAIL mid_reload got %0d want 500", div_count); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_div_change();
    test_min_div();
    test_hold();
    test_off_and_wr();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
